// File: rtl/multilane_fifo_pop_scheduler_if.sv
// Drain-side bundle between the multi-lane FIFO, the pop scheduler and the downstream router.
// The scheduler takes the master view; the FIFO/router environment takes the slave view.
interface multilane_fifo_pop_scheduler_if #(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]      fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [LANES-1:0]      lane_en;
    logic                  pop;
    logic [LW-1:0]         pop_lane;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [LW-1:0]         out_lane;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  lane_en,
        input  out_ready,
        output pop,
        output pop_lane,
        output out_valid,
        output out_data,
        output out_lane
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output lane_en,
        output out_ready,
        input  pop,
        input  pop_lane,
        input  out_valid,
        input  out_data,
        input  out_lane
    );
endinterface

// File: rtl/multilane_fifo_pop_scheduler.sv
// Round-robin pop scheduler with per-lane burst limit feeding a single registered output slot.
// pop/pop_lane are combinational so the FIFO head can be captured in the same cycle it is popped.
module multilane_fifo_pop_scheduler #(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    multilane_fifo_pop_scheduler_if.master bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [LW-1:0]         rr_ptr_q;
    logic [LW-1:0]         rr_ptr_d;
    logic [LW-1:0]         lock_q;
    logic [LW-1:0]         lock_d;
    logic [BW-1:0]         burst_cnt_q;
    logic [BW-1:0]         burst_cnt_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic [LW-1:0]         out_lane_q;
    logic [LW-1:0]         out_lane_d;

    logic [LANES-1:0]      eligible_s;
    logic                  can_load_s;
    logic [LW-1:0]         pick_start_s;
    logic [LW-1:0]         pick_lane_s;
    logic                  pick_found_s;
    logic                  pop_s;
    logic [LW-1:0]         pop_lane_s;

    function automatic logic [LW-1:0] lane_inc(input logic [LW-1:0] lane);
        return (lane == LW'(LANES - 1)) ? {LW{1'b0}} : lane + LW'(1);
    endfunction

    // Returns {found, lane}: first eligible lane scanning upward from start, wrapping at LANES-1.
    function automatic logic [LW:0] rr_pick(input logic [LANES-1:0] elig,
                                            input logic [LW-1:0]    start);
        logic          found;
        logic [LW-1:0] lane;
        int            idx;
        found = 1'b0;
        lane  = start;
        for (int i = 0; i < LANES; i++) begin
            idx = int'(start) + i;
            idx = (idx >= LANES) ? (idx - LANES) : idx;
            if (!found && elig[idx]) begin
                found = 1'b1;
                lane  = LW'(idx);
            end else begin
                found = found;
            end
        end
        return {found, lane};
    endfunction

    assign eligible_s = ~bus.fifo_empty & bus.lane_en;
    assign can_load_s = ~out_valid_q | bus.out_ready;

    // In BURST the scan only matters when the locked lane has dried up, so it starts past the lock.
    assign pick_start_s = (state_q == ST_BURST) ? lane_inc(lock_q) : rr_ptr_q;
    assign {pick_found_s, pick_lane_s} = rr_pick(eligible_s, pick_start_s);

    // Next-state, pop decision and output-slot update.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        burst_cnt_d = burst_cnt_q;
        pop_s       = 1'b0;
        pop_lane_s  = (state_q == ST_BURST) ? lock_q : rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;

        case (state_q)
            ST_IDLE: begin
                if (can_load_s && pick_found_s) begin
                    pop_s       = 1'b1;
                    pop_lane_s  = pick_lane_s;
                    lock_d      = pick_lane_s;
                    burst_cnt_d = BW'(1);
                    if (MAX_BURST > 1) begin
                        state_d = ST_BURST;
                    end else begin
                        rr_ptr_d = lane_inc(pick_lane_s);
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_BURST: begin
                if (!can_load_s) begin
                    pop_s = 1'b0;
                end else if (eligible_s[lock_q]) begin
                    pop_s       = 1'b1;
                    pop_lane_s  = lock_q;
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = lane_inc(lock_q);
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    // Locked lane went dry: hand over in the same cycle so the switch costs no bubble.
                    rr_ptr_d = lane_inc(lock_q);
                    if (pick_found_s) begin
                        pop_s       = 1'b1;
                        pop_lane_s  = pick_lane_s;
                        lock_d      = pick_lane_s;
                        burst_cnt_d = BW'(1);
                        state_d     = ST_BURST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop_s) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.fifo_dout;
            out_lane_d  = pop_lane_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Scheduler state and output slot registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {LW{1'b0}};
            lock_q      <= {LW{1'b0}};
            burst_cnt_q <= {BW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_lane_q  <= {LW{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
        end
    end

    assign bus.pop       = pop_s & reset_ni;
    assign bus.pop_lane  = pop_lane_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lane  = out_lane_q;
endmodule

// File: tb/tb_multilane_fifo_pop_scheduler.sv
// Directed bench: DUT a (MAX_BURST=2) and DUT b (MAX_BURST=4), each fed by a small lane FIFO model.
module tb_multilane_fifo_pop_scheduler;
    logic clk;
    logic rst_n;

    multilane_fifo_pop_scheduler_if #(.LANES(2), .DATA_WIDTH(32)) if_a ();
    multilane_fifo_pop_scheduler_if #(.LANES(2), .DATA_WIDTH(32)) if_b ();

    multilane_fifo_pop_scheduler #(.LANES(2), .DATA_WIDTH(32), .MAX_BURST(2)) dut_a (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (if_a.master)
    );

    multilane_fifo_pop_scheduler #(.LANES(2), .DATA_WIDTH(32), .MAX_BURST(4)) dut_b (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (if_b.master)
    );

    // Lane FIFO model: [instance][lane][entry]; pointers wrap at 16.
    bit [31:0] fmem [2][2][16];
    bit [3:0]  fwr  [2][2];
    bit [3:0]  frd  [2][2];
    int        bad_pops = 0;
    int        n_checks = 0;
    int        n_fail   = 0;

    assign if_a.fifo_empty = {frd[0][1] == fwr[0][1], frd[0][0] == fwr[0][0]};
    assign if_b.fifo_empty = {frd[1][1] == fwr[1][1], frd[1][0] == fwr[1][0]};
    assign if_a.fifo_dout  = fmem[0][if_a.pop_lane][frd[0][if_a.pop_lane]];
    assign if_b.fifo_dout  = fmem[1][if_b.pop_lane][frd[1][if_b.pop_lane]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO read side: advance on pop, and flag any pop of an empty or disabled lane.
    always @(posedge clk) begin
        if (if_a.pop) begin
            frd[0][if_a.pop_lane] <= frd[0][if_a.pop_lane] + 4'd1;
            if (frd[0][if_a.pop_lane] == fwr[0][if_a.pop_lane] || !if_a.lane_en[if_a.pop_lane])
                bad_pops <= bad_pops + 1;
        end
        if (if_b.pop) begin
            frd[1][if_b.pop_lane] <= frd[1][if_b.pop_lane] + 4'd1;
            if (frd[1][if_b.pop_lane] == fwr[1][if_b.pop_lane] || !if_b.lane_en[if_b.pop_lane])
                bad_pops <= bad_pops + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wa(input int k);
        return 32'hA000_0000 | 32'(k);
    endfunction

    function automatic logic [31:0] wb(input int k);
        return 32'hB000_0000 | 32'(k);
    endfunction

    task automatic push(input int inst, input int lane, input logic [31:0] d);
        fmem[inst][lane][fwr[inst][lane]] = d;
        fwr[inst][lane] = fwr[inst][lane] + 4'd1;
    endtask

    // Advance one cycle and check the output slot of the chosen instance.
    task automatic step_expect(input string tag, input int inst, input logic [31:0] d, input logic lane);
        @(negedge clk);
        chk_eq({tag, "_valid"}, (inst == 1) ? if_b.out_valid : if_a.out_valid, 64'd1);
        chk_eq({tag, "_data"},  (inst == 1) ? if_b.out_data  : if_a.out_data,  {32'd0, d});
        chk_eq({tag, "_lane"},  (inst == 1) ? if_b.out_lane  : if_a.out_lane,  {63'd0, lane});
    endtask

    task automatic step_empty(input string tag, input int inst);
        @(negedge clk);
        chk_eq({tag, "_novalid"}, (inst == 1) ? if_b.out_valid : if_a.out_valid, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [3:0] lane1_rd;
        rst_n          = 1'b0;
        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;
        if_a.lane_en   = 2'b11;
        if_b.lane_en   = 2'b11;
        for (int k = 0; k < 4; k++) begin
            push(0, 0, wa(k));
            push(0, 1, wb(k));
        end

        // Reset held with both lanes non-empty.
        @(negedge clk);
        chk_eq("rst_pop",   if_a.pop,       64'd0);
        chk_eq("rst_valid", if_a.out_valid, 64'd0);
        chk_eq("rst_data",  if_a.out_data,  64'd0);
        chk_eq("rst_lane",  if_a.out_lane,  64'd0);
        chk_eq("rst_pop_b", if_b.pop,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_eq("rel_pop",      if_a.pop,      64'd1);
        chk_eq("rel_pop_lane", if_a.pop_lane, 64'd0);

        // Round-robin with burst of two.
        step_expect("rr_a0", 0, wa(0), 1'b0);
        step_expect("rr_a1", 0, wa(1), 1'b0);
        step_expect("rr_b0", 0, wb(0), 1'b1);
        step_expect("rr_b1", 0, wb(1), 1'b1);
        step_expect("rr_a2", 0, wa(2), 1'b0);
        step_expect("rr_a3", 0, wa(3), 1'b0);
        step_expect("rr_b2", 0, wb(2), 1'b1);
        step_expect("rr_b3", 0, wb(3), 1'b1);
        step_empty("rr_end", 0);

        // Backpressure: slot frozen while out_ready is low.
        if_a.out_ready = 1'b0;
        push(0, 0, wa(4));
        push(0, 0, wa(5));
        push(0, 0, wa(6));
        step_expect("bp_a4", 0, wa(4), 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("bp_pop",   if_a.pop,      64'd0);
            chk_eq("bp_valid", if_a.out_valid, 64'd1);
            chk_eq("bp_data",  if_a.out_data,  {32'd0, wa(4)});
        end
        if_a.out_ready = 1'b1;
        step_expect("bp_a5", 0, wa(5), 1'b0);
        step_expect("bp_a6", 0, wa(6), 1'b0);
        step_empty("bp_end", 0);

        // Lane switch inside a long burst with no bubble (MAX_BURST=4).
        push(1, 0, wa(16));
        push(1, 1, wb(16));
        push(1, 1, wb(17));
        push(1, 1, wb(18));
        step_expect("sw_a16", 1, wa(16), 1'b0);
        step_expect("sw_b16", 1, wb(16), 1'b1);
        step_expect("sw_b17", 1, wb(17), 1'b1);
        step_expect("sw_b18", 1, wb(18), 1'b1);
        step_empty("sw_end", 1);

        // Lane mask: lane 1 disabled, then enabled.
        if_a.lane_en = 2'b01;
        for (int k = 32; k < 36; k++) push(0, 0, wa(k));
        push(0, 1, wb(32));
        push(0, 1, wb(33));
        lane1_rd = frd[0][1];
        step_expect("en_a32", 0, wa(32), 1'b0);
        step_expect("en_a33", 0, wa(33), 1'b0);
        step_expect("en_a34", 0, wa(34), 1'b0);
        step_expect("en_a35", 0, wa(35), 1'b0);
        step_empty("en_idle", 0);
        chk_eq("en_lane1_untouched", {60'd0, frd[0][1]}, {60'd0, lane1_rd});
        if_a.lane_en = 2'b11;
        step_expect("en_b32", 0, wb(32), 1'b1);
        step_expect("en_b33", 0, wb(33), 1'b1);
        step_empty("en_end", 0);

        // Reset asserted mid-burst on lane 1.
        for (int k = 48; k < 52; k++) begin
            push(0, 0, wa(k));
            push(0, 1, wb(k));
        end
        step_expect("mr_a48", 0, wa(48), 1'b0);
        step_expect("mr_a49", 0, wa(49), 1'b0);
        step_expect("mr_b48", 0, wb(48), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("mr_valid_drop", if_a.out_valid, 64'd0);
        chk_eq("mr_pop_off",    if_a.pop,       64'd0);
        @(negedge clk);
        chk_eq("mr_valid_held", if_a.out_valid, 64'd0);
        rst_n = 1'b1;
        #1;
        chk_eq("mr_rel_pop",      if_a.pop,      64'd1);
        chk_eq("mr_rel_pop_lane", if_a.pop_lane, 64'd0);
        step_expect("mr_a50", 0, wa(50), 1'b0);
        step_expect("mr_a51", 0, wa(51), 1'b0);
        step_expect("mr_b49", 0, wb(49), 1'b1);
        step_expect("mr_b50", 0, wb(50), 1'b1);
        step_expect("mr_b51", 0, wb(51), 1'b1);
        step_empty("mr_end", 0);

        @(negedge clk);
        chk_eq("bad_pops", 64'(bad_pops), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
